// File: rtl/io_bus_master.sv
// io_bus_master: one-at-a-time initiator for the shared memory-mapped I/O bus.
// Requests are decoded when accepted; illegal addresses answer with resp_err and never reach the bus.
module io_bus_master #(
    parameter int unsigned       DBITS       = 32,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [DBITS-1:0]  DMEM_BYTES  = 32'h2000,
    parameter logic [DBITS-1:0]  IO_BASE     = 32'hF000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [DBITS-1:0] req_addr,
    input  logic [DBITS-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DBITS-1:0] resp_rdata,
    output logic             resp_err,
    output logic [DBITS-1:0] ABUS,
    inout  wire  [DBITS-1:0] DBUS,
    output logic             we
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    // Legal targets: aligned words inside DMEM or one of the five device registers.
    function automatic logic addr_legal(input logic [DBITS-1:0] addr);
        logic legal;
        if (addr[1:0] != 2'b00) begin
            legal = 1'b0;
        end else if (addr < DMEM_BYTES) begin
            legal = 1'b1;
        end else if ((addr == IO_BASE) ||
                     (addr == IO_BASE + DBITS'(8'h04)) ||
                     (addr == IO_BASE + DBITS'(8'h08)) ||
                     (addr == IO_BASE + DBITS'(8'h10)) ||
                     (addr == IO_BASE + DBITS'(8'h14))) begin
            legal = 1'b1;
        end else begin
            legal = 1'b0;
        end
        return legal;
    endfunction

    state_t             state_r, state_n;
    logic [3:0]         cnt_r, cnt_n;
    logic               lat_we_r;
    logic [DBITS-1:0]   lat_wdata_r;
    logic               req_ready_r, req_ready_n;
    logic               resp_valid_r, resp_valid_n;
    logic               resp_err_r, resp_err_n;
    logic [DBITS-1:0]   resp_rdata_r, resp_rdata_n;
    logic [DBITS-1:0]   abus_r, abus_n;
    logic               we_r, we_n;
    logic               dbus_oe_r, dbus_oe_n;
    logic               accept_s;
    logic               legal_s;
    logic               sample_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);
    assign legal_s  = addr_legal(req_addr);
    assign sample_s = (state_r == ST_ACCESS) && (cnt_r == 4'd0) && !lat_we_r;

    // State register together with the latched request and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            lat_we_r     <= 1'b0;
            lat_wdata_r  <= {DBITS{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DBITS{1'b0}};
            abus_r       <= {DBITS{1'b0}};
            we_r         <= 1'b0;
            dbus_oe_r    <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            req_ready_r  <= req_ready_n;
            resp_valid_r <= resp_valid_n;
            resp_err_r   <= resp_err_n;
            resp_rdata_r <= resp_rdata_n;
            abus_r       <= abus_n;
            we_r         <= we_n;
            dbus_oe_r    <= dbus_oe_n;
            if (accept_s) begin
                lat_we_r    <= req_we;
                lat_wdata_r <= req_wdata;
            end
        end
    end

    // Next-state sequencing and the saturating wait counter.
    always_comb begin
        state_n = state_r;
        if (cnt_r != 4'd0) begin
            cnt_n = cnt_r - 4'd1;
        end else begin
            cnt_n = 4'd0;
        end
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n = legal_s ? ST_SETUP : ST_RESP;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_n = ST_ACCESS;
                cnt_n   = WAIT_LOAD;
            end
            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so they can be registered without lag.
    always_comb begin
        req_ready_n  = (state_n == ST_IDLE);
        resp_valid_n = (state_n == ST_RESP);
        we_n         = (state_n == ST_ACCESS) && (cnt_n == 4'd0) && lat_we_r;
        dbus_oe_n    = (state_n == ST_ACCESS) && lat_we_r;
        abus_n       = abus_r;
        resp_err_n   = resp_err_r;
        resp_rdata_n = resp_rdata_r;
        if (accept_s) begin
            resp_err_n   = !legal_s;
            resp_rdata_n = {DBITS{1'b0}};
            if (legal_s) begin
                abus_n = req_addr;
            end else begin
                abus_n = abus_r;
            end
        end else if (sample_s) begin
            resp_rdata_n = DBUS;
        end else begin
            resp_rdata_n = resp_rdata_r;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    assign ABUS       = abus_r;
    assign we         = we_r;
    assign DBUS       = dbus_oe_r ? lat_wdata_r : {DBITS{1'bz}};

endmodule
